exception_handler: RTL and testbench

- Consumer side of the exception-code path: accepts the 32-bit exception code the decode logic produces (1 = add overflow, 3 = sub overflow, 2 = addi overflow, 0 = none), plus the faulting PC.
- Sequences the pipeline response: flush, commit the code to the status register ($r30) through a regfile write handshake, then redirect fetch to the handler address.
- Sits beside the writeback stage; drives the regfile write-port mux and the PC select.

---
 rtl/exception_handler_if.sv | 39 +++
 rtl/exception_handler.sv | 123 ++++++++++++
 tb/tb_exception_handler.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exception_handler_if.sv
// ---------------------------------------------------------------------------
// exception_handler_if
//   Bundles the exception-code path between the pipeline (master) and the
//   exception sequencer (slave).
//   master drives : exc_valid, exc_code, exc_pc, rf_wr_ready
//   slave drives  : flush, stall, rf_wren, rf_waddr, rf_wdata, pc_redirect,
//                   pc_target, epc, cause, busy, dropped, exc_count
// ---------------------------------------------------------------------------
interface exception_handler_if;
    logic        exc_valid;
    logic [31:0] exc_code;
    logic [31:0] exc_pc;
    logic        rf_wr_ready;

    logic        flush;
    logic        stall;
    logic        rf_wren;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        busy;
    logic        dropped;
    logic [7:0]  exc_count;

    modport master (
        output exc_valid, exc_code, exc_pc, rf_wr_ready,
        input  flush, stall, rf_wren, rf_waddr, rf_wdata, pc_redirect,
               pc_target, epc, cause, busy, dropped, exc_count
    );

    modport slave (
        input  exc_valid, exc_code, exc_pc, rf_wr_ready,
        output flush, stall, rf_wren, rf_waddr, rf_wdata, pc_redirect,
               pc_target, epc, cause, busy, dropped, exc_count
    );
endinterface

// File: rtl/exception_handler.sv
// ---------------------------------------------------------------------------
// exception_handler
//   Accepts a non-zero exception code with its faulting PC, then sequences
//   the pipeline response: flush for FLUSH_CYCLES cycles, write the code to
//   the status register through the regfile write handshake, and issue a
//   one-cycle fetch redirect to HANDLER_ADDR.
//   Ports:
//     clock  - system clock, rising edge
//     reset  - synchronous active-high reset
//     bus    - exception_handler_if.slave (inputs exc_*/rf_wr_ready,
//              outputs flush/stall/regfile write/redirect/status)
//   Every output is decoded from registered state only.
// ---------------------------------------------------------------------------
module exception_handler #(
    parameter int          STATUS_REG   = 30,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 3
) (
    input  logic                clock,
    input  logic                reset,
    exception_handler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WRITE = 2'd2,
        ST_REDIR = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] epc_q,       epc_d;
    logic [31:0] cause_q,     cause_d;
    logic [7:0]  exc_count_q, exc_count_d;
    logic        dropped_q,   dropped_d;

    logic        exc_present;

    // A zero code is never an exception, whatever exc_valid says.
    assign exc_present = bus.exc_valid && (bus.exc_code != 32'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 4'd0;
            epc_q       <= 32'd0;
            cause_q     <= 32'd0;
            exc_count_q <= 8'd0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            exc_count_q <= exc_count_d;
            dropped_q   <= dropped_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        exc_count_d = exc_count_q;
        dropped_d   = dropped_q;

        // Anything arriving while a sequence is in progress is lost, not
        // queued; the sticky flag lets software notice.
        if (state_q != ST_IDLE && exc_present) begin
            dropped_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (exc_present) begin
                    cause_d     = bus.exc_code;
                    epc_d       = bus.exc_pc;
                    if (exc_count_q != 8'hFF) begin
                        exc_count_d = exc_count_q + 8'd1;
                    end
                    // Counter loaded with N-1 so FLUSH lasts N cycles.
                    flush_cnt_d = 4'(FLUSH_CYCLES - 1);
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_WRITE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            ST_WRITE: begin
                if (bus.rf_wr_ready) begin
                    state_d = ST_REDIR;
                end
            end
            ST_REDIR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: pure functions of registered state.
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.stall       = (state_q != ST_IDLE);
    assign bus.flush       = (state_q == ST_FLUSH);
    assign bus.rf_wren     = (state_q == ST_WRITE);
    assign bus.rf_waddr    = (state_q == ST_WRITE) ? 5'(STATUS_REG) : 5'd0;
    assign bus.rf_wdata    = (state_q == ST_WRITE) ? cause_q : 32'd0;
    assign bus.pc_redirect = (state_q == ST_REDIR);
    assign bus.pc_target   = (state_q == ST_REDIR) ? HANDLER_ADDR : 32'd0;
    assign bus.epc         = epc_q;
    assign bus.cause       = cause_q;
    assign bus.dropped     = dropped_q;
    assign bus.exc_count   = exc_count_q;

endmodule

// File: tb/tb_exception_handler.sv
// ---------------------------------------------------------------------------
// tb_exception_handler
//   Two instances share one stimulus stream: u0 with FLUSH_CYCLES=3 and
//   u1 with FLUSH_CYCLES=1. A timeline model (accept edge, grant cycle)
//   predicts every output of both instances each cycle; directed sections
//   add literal expectations for u0 (and u1's short flush).
// ---------------------------------------------------------------------------
module tb_exception_handler;

    typedef struct packed {
        logic        flush;
        logic        stall;
        logic        rf_wren;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        pc_redirect;
        logic [31:0] pc_target;
        logic [31:0] epc;
        logic [31:0] cause;
        logic        busy;
        logic        dropped;
        logic [7:0]  exc_count;
    } obs_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [31:0] exc_code;
    logic [31:0] exc_pc;
    logic        rf_wr_ready;

    int checks = 0;
    int errors = 0;

    exception_handler_if bus0();
    exception_handler_if bus1();

    assign bus0.exc_valid   = exc_valid;
    assign bus0.exc_code    = exc_code;
    assign bus0.exc_pc      = exc_pc;
    assign bus0.rf_wr_ready = rf_wr_ready;
    assign bus1.exc_valid   = exc_valid;
    assign bus1.exc_code    = exc_code;
    assign bus1.exc_pc      = exc_pc;
    assign bus1.rf_wr_ready = rf_wr_ready;

    exception_handler #(.STATUS_REG(30), .HANDLER_ADDR(32'h0000_0100), .FLUSH_CYCLES(3))
        u0 (.clock(clock), .reset(reset), .bus(bus0.slave));
    exception_handler #(.STATUS_REG(30), .HANDLER_ADDR(32'h0000_0100), .FLUSH_CYCLES(1))
        u1 (.clock(clock), .reset(reset), .bus(bus1.slave));

    always #5 clock = ~clock;

    obs_t obs0, obs1;
    always_comb begin
        obs0 = '{flush: bus0.flush, stall: bus0.stall, rf_wren: bus0.rf_wren,
                 rf_waddr: bus0.rf_waddr, rf_wdata: bus0.rf_wdata,
                 pc_redirect: bus0.pc_redirect, pc_target: bus0.pc_target,
                 epc: bus0.epc, cause: bus0.cause, busy: bus0.busy,
                 dropped: bus0.dropped, exc_count: bus0.exc_count};
        obs1 = '{flush: bus1.flush, stall: bus1.stall, rf_wren: bus1.rf_wren,
                 rf_waddr: bus1.rf_waddr, rf_wdata: bus1.rf_wdata,
                 pc_redirect: bus1.pc_redirect, pc_target: bus1.pc_target,
                 epc: bus1.epc, cause: bus1.cause, busy: bus1.busy,
                 dropped: bus1.dropped, exc_count: bus1.exc_count};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model. Cycle e is the interval after clock edge e.
    // Accept at edge a: flush cycles a..a+F-1, write from a+F until the
    // cycle g in which ready is seen, redirect in cycle g+1, idle after.
    // ------------------------------------------------------------------
    obs_t        exp_s [2];
    bit          m_active [2];
    int          m_acc [2];
    int          m_grant [2];
    logic [31:0] m_cause [2];
    logic [31:0] m_epc [2];
    int          m_cnt [2];
    bit          m_drop [2];
    bit          model_ok = 1'b0;
    int          edge_no = 0;

    function automatic int flush_len(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    task automatic model_edge(input int i, input int e);
        obs_t x;
        int   prev;
        prev = e - 1;
        if (reset) begin
            m_active[i] = 1'b0;
            m_cause[i]  = 32'd0;
            m_epc[i]    = 32'd0;
            m_cnt[i]    = 0;
            m_drop[i]   = 1'b0;
        end else if (m_active[i]) begin
            if (exc_valid && exc_code != 0) m_drop[i] = 1'b1;
            if (m_grant[i] < 0 && prev >= m_acc[i] + flush_len(i) && rf_wr_ready)
                m_grant[i] = prev;
            else if (m_grant[i] >= 0 && prev == m_grant[i] + 1)
                m_active[i] = 1'b0;
        end else if (exc_valid && exc_code != 0) begin
            m_active[i] = 1'b1;
            m_acc[i]    = e;
            m_grant[i]  = -1;
            m_cause[i]  = exc_code;
            m_epc[i]    = exc_pc;
            if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        end
        x = '0;
        if (m_active[i]) begin
            x.busy  = 1'b1;
            x.stall = 1'b1;
            if (e < m_acc[i] + flush_len(i)) begin
                x.flush = 1'b1;
            end else if (m_grant[i] < 0) begin
                x.rf_wren  = 1'b1;
                x.rf_waddr = 5'd30;
                x.rf_wdata = m_cause[i];
            end else begin
                x.pc_redirect = 1'b1;
                x.pc_target   = 32'h0000_0100;
            end
        end
        x.epc       = m_epc[i];
        x.cause     = m_cause[i];
        x.dropped   = m_drop[i];
        x.exc_count = 8'(m_cnt[i]);
        exp_s[i] = x;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            edge_no++;
            model_edge(0, edge_no);
            model_edge(1, edge_no);
            if (reset) model_ok = 1'b1;
        end
    end

    task automatic cmp(input int i, input obs_t a, input obs_t x);
        check($sformatf("u%0d.flush", i),       32'(a.flush),       32'(x.flush));
        check($sformatf("u%0d.stall", i),       32'(a.stall),       32'(x.stall));
        check($sformatf("u%0d.rf_wren", i),     32'(a.rf_wren),     32'(x.rf_wren));
        check($sformatf("u%0d.rf_waddr", i),    32'(a.rf_waddr),    32'(x.rf_waddr));
        check($sformatf("u%0d.rf_wdata", i),    a.rf_wdata,         x.rf_wdata);
        check($sformatf("u%0d.pc_redirect", i), 32'(a.pc_redirect), 32'(x.pc_redirect));
        check($sformatf("u%0d.pc_target", i),   a.pc_target,        x.pc_target);
        check($sformatf("u%0d.epc", i),         a.epc,              x.epc);
        check($sformatf("u%0d.cause", i),       a.cause,            x.cause);
        check($sformatf("u%0d.busy", i),        32'(a.busy),        32'(x.busy));
        check($sformatf("u%0d.dropped", i),     32'(a.dropped),     32'(x.dropped));
        check($sformatf("u%0d.exc_count", i),   32'(a.exc_count),   32'(x.exc_count));
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (model_ok) begin
                cmp(0, obs0, exp_s[0]);
                cmp(1, obs1, exp_s[1]);
            end
        end
    end

    // One step: advance one edge, then act 2 time units into the new cycle.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    logic [5:0]  f0, w0, r0, f1, w1, r1;
    logic [31:0] wd_cap, wa_cap, tg_cap;
    int          cnt_a, cnt_b, at_a, at_b;
    logic        seen;

    initial begin
        reset = 1'b1; exc_valid = 1'b0; exc_code = 32'd0; exc_pc = 32'd0; rf_wr_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        check("reset_outputs_u0", 32'(obs0 != '0), 32'd0);
        check("reset_outputs_u1", 32'(obs1 != '0), 32'd0);
        $display("txn reset: outputs cleared");

        // Zero code with exc_valid is ignored.
        exc_valid = 1'b1; exc_code = 32'd0; exc_pc = 32'h0000_dead; rf_wr_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen = seen | bus0.busy | bus0.flush | bus0.rf_wren | bus1.busy | bus1.rf_wren;
        end
        exc_valid = 1'b0;
        check("zero_code_activity", 32'(seen), 32'd0);
        check("zero_code_count", 32'(bus0.exc_count), 32'd0);
        $display("txn zero-code: 10 cycles, no activity");

        // Basic sequence: code 1, ready high.
        exc_valid = 1'b1; exc_code = 32'd1; exc_pc = 32'h40;
        step();
        exc_valid = 1'b0;
        wd_cap = '0; wa_cap = '0; tg_cap = '0;
        for (int k = 0; k < 6; k++) begin
            f0[k] = bus0.flush; w0[k] = bus0.rf_wren; r0[k] = bus0.pc_redirect;
            f1[k] = bus1.flush; w1[k] = bus1.rf_wren; r1[k] = bus1.pc_redirect;
            if (k == 3) begin wd_cap = bus0.rf_wdata; wa_cap = 32'(bus0.rf_waddr); end
            if (k == 4) tg_cap = bus0.pc_target;
            step();
        end
        check("basic_flush_u0", 32'(f0), 32'h07);
        check("basic_wren_u0",  32'(w0), 32'h08);
        check("basic_redir_u0", 32'(r0), 32'h10);
        check("basic_flush_u1", 32'(f1), 32'h01);
        check("basic_wren_u1",  32'(w1), 32'h02);
        check("basic_redir_u1", 32'(r1), 32'h04);
        check("basic_wdata", wd_cap, 32'd1);
        check("basic_waddr", wa_cap, 32'd30);
        check("basic_target", tg_cap, 32'h100);
        check("basic_cause", bus0.cause, 32'd1);
        check("basic_epc", bus0.epc, 32'h40);
        check("basic_count", 32'(bus0.exc_count), 32'd1);
        check("basic_dropped", 32'(bus0.dropped), 32'd0);
        $display("txn code=1 pc=40: flush/write/redirect sequence");

        // Write held off by rf_wr_ready low for 4 write cycles.
        exc_valid = 1'b1; exc_code = 32'd3; exc_pc = 32'h80; rf_wr_ready = 1'b0;
        step();
        exc_valid = 1'b0;
        cnt_a = 0; at_a = 0; seen = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (bus0.rf_wren) begin
                cnt_a++;
                check("stall_wdata", bus0.rf_wdata, 32'd3);
            end
            if (bus0.pc_redirect) at_a = i;
            if (i <= 9) seen = seen & bus0.stall;
            rf_wr_ready = (i >= 8);
            step();
        end
        check("stall_wren_cycles", 32'(cnt_a), 32'd5);
        check("stall_redir_step", 32'(at_a), 32'd9);
        check("stall_held", 32'(seen), 32'd1);
        $display("txn code=3 pc=80: write held 5 cycles");

        // Exceptions during FLUSH and REDIR are dropped.
        exc_valid = 1'b1; exc_code = 32'd2; exc_pc = 32'hc0;
        step();
        exc_valid = 1'b0; exc_code = 32'd1;
        cnt_a = 0;
        for (int i = 1; i <= 12; i++) begin
            if (bus0.pc_redirect) cnt_a++;
            exc_valid = (i == 2) || (i == 5);
            step();
        end
        exc_valid = 1'b0;
        check("drop_flag", 32'(bus0.dropped), 32'd1);
        check("drop_cause", bus0.cause, 32'd2);
        check("drop_epc", bus0.epc, 32'hc0);
        check("drop_count", 32'(bus0.exc_count), 32'd3);
        check("drop_redirs", 32'(cnt_a), 32'd1);
        $display("txn code=2 pc=c0: two arrivals dropped");

        // Reset while waiting in WRITE aborts the sequence.
        exc_valid = 1'b1; exc_code = 32'd1; exc_pc = 32'h200; rf_wr_ready = 1'b0;
        step();
        exc_valid = 1'b0;
        step(); step(); step();
        check("abort_in_write", 32'(bus0.rf_wren), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; rf_wr_ready = 1'b1;
        check("abort_zero_u0", 32'(obs0 != '0), 32'd0);
        check("abort_zero_u1", 32'(obs1 != '0), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | bus0.rf_wren | bus0.pc_redirect;
            step();
        end
        check("abort_no_write_redir", 32'(seen), 32'd0);
        exc_valid = 1'b1; exc_code = 32'd1; exc_pc = 32'h204;
        step();
        exc_valid = 1'b0;
        at_a = 0;
        for (int i = 1; i <= 6; i++) begin
            if (bus0.pc_redirect && at_a == 0) at_a = i;
            step();
        end
        check("after_abort_redir_step", 32'(at_a), 32'd5);
        check("after_abort_cause", bus0.cause, 32'd1);
        check("after_abort_count", 32'(bus0.exc_count), 32'd1);
        $display("txn reset-in-write: aborted, next code=1 accepted");

        // Back-to-back exceptions until the counter saturates.
        exc_valid = 1'b1; exc_code = 32'd1; exc_pc = 32'h300; rf_wr_ready = 1'b1;
        step();
        cnt_a = 0; cnt_b = 0; at_a = 0; at_b = 0;
        for (int s = 1; s <= 1560; s++) begin
            if (bus0.pc_redirect) begin
                cnt_a++;
                if (cnt_a == 1) at_a = s;
                if (cnt_a == 2) at_b = s;
            end
            if (bus1.pc_redirect) cnt_b++;
            step();
        end
        exc_valid = 1'b0;
        check("sat_count_u0", 32'(bus0.exc_count), 32'd255);
        check("sat_count_u1", 32'(bus1.exc_count), 32'd255);
        check("sat_redirs_u0", 32'(cnt_a), 32'd260);
        check("sat_first_redir", 32'(at_a), 32'd5);
        check("sat_period", 32'(at_b - at_a), 32'd6);
        $display("txn back-to-back: %0d redirects u0, %0d redirects u1", cnt_a, cnt_b);

        step(); step(); step(); step(); step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
